// File: rtl/ecc64_pkg.sv
// Shared ECC constants for the 72/64 SEC-DED path: widths, H column table, decode class.
package ecc64_pkg;

  localparam int DATA_W = 64;
  localparam int CHK_W  = 8;
  localparam int CODE_W = DATA_W + CHK_W;
  localparam int SYN_W  = CHK_W;
  localparam int POS_W  = 7;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SEC   = 2'd1,
    DED   = 2'd2
  } ecc_class_e;

  // Data columns of H: distinct, odd weight (3 or 5), never one-hot.
  localparam logic [SYN_W-1:0] H_COL [0:DATA_W-1] = '{
    8'h23, 8'h07, 8'h0B, 8'h3D, 8'h0D, 8'h0E, 8'h13, 8'h15,
    8'h16, 8'h19, 8'h1A, 8'h1C, 8'h25, 8'h26, 8'h29, 8'h2A,
    8'h2C, 8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46,
    8'h49, 8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61,
    8'h62, 8'h64, 8'h68, 8'h70, 8'h83, 8'h85, 8'h86, 8'h89,
    8'h8A, 8'h8C, 8'h91, 8'h92, 8'h94, 8'h98, 8'hA1, 8'hA2,
    8'hA4, 8'hA8, 8'hB0, 8'hC1, 8'hC2, 8'hC4, 8'hC8, 8'hD0,
    8'hE0, 8'h1F, 8'h2F, 8'h37, 8'h3B, 8'h3E, 8'h4F, 8'h57
  };

endpackage

// File: rtl/ecc_syn_decode.sv
// Combinational syndrome decode: classifies a syndrome and locates the bit to flip.
module ecc_syn_decode
  import ecc64_pkg::*;
(
  input  logic [SYN_W-1:0] syn_i,
  input  logic             err_i,
  output ecc_class_e       cls_o,
  output logic [POS_W-1:0] pos_o
);

  logic             col_hit;
  logic [POS_W-1:0] col_pos;
  logic [POS_W-1:0] chk_pos;

  always_comb begin
    col_hit = 1'b0;
    col_pos = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (syn_i == H_COL[i]) begin
        col_hit = 1'b1;
        col_pos = POS_W'(i);
      end
    end
  end

  // Check-bit positions are encoded above the data range as DATA_W + k.
  always_comb begin
    chk_pos = '0;
    for (int k = 0; k < CHK_W; k++) begin
      if (syn_i[k]) chk_pos = POS_W'(DATA_W + k);
    end
  end

  always_comb begin
    cls_o = CLEAN;
    pos_o = '0;
    if (err_i != (|syn_i)) begin
      cls_o = DED;
    end else if (syn_i == '0) begin
      cls_o = CLEAN;
    end else if ($onehot(syn_i)) begin
      cls_o = SEC;
      pos_o = chk_pos;
    end else if (!(^syn_i)) begin
      cls_o = DED;
    end else if (col_hit) begin
      cls_o = SEC;
      pos_o = col_pos;
    end else begin
      cls_o = DED;
    end
  end

endmodule

// File: rtl/ecc_correct64.sv
// Two-stage SEC-DED correction pipeline with valid/ready handshakes and saturating event counters.
module ecc_correct64
  import ecc64_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [SYN_W-1:0]  in_syn,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [SYN_W-1:0]  out_syn,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  ecc_class_e        dec_cls;
  logic [POS_W-1:0]  dec_pos;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [SYN_W-1:0]  s1_syn_q;
  ecc_class_e        s1_cls_q;
  logic [POS_W-1:0]  s1_pos_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_sec_q;
  logic              out_ded_q;
  logic [SYN_W-1:0]  out_syn_q;

  logic [CNT_W-1:0]  sec_cnt_q;
  logic [CNT_W-1:0]  ded_cnt_q;

  logic              s1_adv;
  logic              s2_adv;
  logic              out_xfer;
  logic [DATA_W-1:0] flip_mask;
  logic [DATA_W-1:0] data_d;

  // Check bits are not needed: the syndrome stage already summarised them.
  logic unused_chk;
  assign unused_chk = ^in_code[CODE_W-1:DATA_W];

  ecc_syn_decode u_dec (
    .syn_i (in_syn),
    .err_i (in_err),
    .cls_o (dec_cls),
    .pos_o (dec_pos)
  );

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    flip_mask = '0;
    if (s1_cls_q == SEC && !s1_pos_q[POS_W-1]) flip_mask[s1_pos_q[5:0]] = 1'b1;
    data_d = s1_data_q ^ flip_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s1_cls_q   <= CLEAN;
      s1_pos_q   <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_code[DATA_W-1:0];
        s1_syn_q  <= in_syn;
        s1_cls_q  <= dec_cls;
        s1_pos_q  <= dec_pos;
      end
    end
  end

  // Output fields are zeroed whenever the stage empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      out_syn_q   <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      out_data_q  <= s1_valid_q ? data_d : '0;
      out_sec_q   <= s1_valid_q && (s1_cls_q == SEC);
      out_ded_q   <= s1_valid_q && (s1_cls_q == DED);
      out_syn_q   <= s1_valid_q ? s1_syn_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else if (clr_cnt) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      if (out_xfer && out_sec_q && sec_cnt_q != {CNT_W{1'b1}}) sec_cnt_q <= sec_cnt_q + 1'b1;
      if (out_xfer && out_ded_q && ded_cnt_q != {CNT_W{1'b1}}) ded_cnt_q <= ded_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sec   = out_sec_q;
  assign out_ded   = out_ded_q;
  assign out_syn   = out_syn_q;
  assign sec_cnt   = sec_cnt_q;
  assign ded_cnt   = ded_cnt_q;

endmodule

// File: tb/tb_ecc_correct64.sv
// Directed bench for ecc_correct64 (CNT_W=4): decode classes, backpressure, saturation, reset flush.
module tb_ecc_correct64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_code;
  logic [7:0]  in_syn;
  logic        in_err;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sec;
  logic        out_ded;
  logic [7:0]  out_syn;
  logic        clr_cnt;
  logic [3:0]  sec_cnt;
  logic [3:0]  ded_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] s_raw [8];
  logic [63:0] s_exp [8];
  logic [7:0]  s_syn [8];
  logic        s_sec [8];
  logic        s_ded [8];
  logic        pat   [4];

  always #5 clk = ~clk;

  ecc_correct64 #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_syn    (in_syn),
    .in_err    (in_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sec   (out_sec),
    .out_ded   (out_ded),
    .out_syn   (out_syn),
    .clr_cnt   (clr_cnt),
    .sec_cnt   (sec_cnt),
    .ded_cnt   (ded_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with out_ready high; leaves the pipe empty.
  task automatic send_single(input string tag, input logic [63:0] data, input logic [7:0] chkb,
                             input logic [7:0] syn, input logic err, input logic [63:0] exp_data,
                             input logic exp_sec, input logic exp_ded);
    in_valid = 1'b1;
    in_code  = {chkb, data};
    in_syn   = syn;
    in_err   = err;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_code  = '0;
    in_syn   = '0;
    in_err   = 1'b0;
    check({tag, ".early_valid"}, out_valid, 1'b0);
    check({tag, ".idle_data"}, out_data, 64'h0);
    @(posedge clk); #1;
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".data"}, out_data, exp_data);
    check({tag, ".sec"}, out_sec, exp_sec);
    check({tag, ".ded"}, out_ded, exp_ded);
    check({tag, ".syn"}, out_syn, syn);
    @(posedge clk); #1;
    check({tag, ".drained"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; in_syn = '0; in_err = 1'b0;
    out_ready = 1'b1; clr_cnt = 1'b0;

    s_raw[0] = 64'h0000_0000_0000_0001; s_syn[0] = 8'h00; s_exp[0] = 64'h0000_0000_0000_0001; s_sec[0] = 0; s_ded[0] = 0;
    s_raw[1] = 64'hFFFF_FFFF_FFFF_FFFF; s_syn[1] = 8'h00; s_exp[1] = 64'hFFFF_FFFF_FFFF_FFFF; s_sec[1] = 0; s_ded[1] = 0;
    s_raw[2] = 64'hA5A5_A5A5_A5A5_A5AD; s_syn[2] = 8'h3D; s_exp[2] = 64'hA5A5_A5A5_A5A5_A5A5; s_sec[2] = 1; s_ded[2] = 0;
    s_raw[3] = 64'h1234_5678_9ABC_DEF0; s_syn[3] = 8'h00; s_exp[3] = 64'h1234_5678_9ABC_DEF0; s_sec[3] = 0; s_ded[3] = 0;
    s_raw[4] = 64'h8000_0000_0000_0000; s_syn[4] = 8'h57; s_exp[4] = 64'h0000_0000_0000_0000; s_sec[4] = 1; s_ded[4] = 0;
    s_raw[5] = 64'h0F0F_0F0F_0F0F_0F06; s_syn[5] = 8'h1E; s_exp[5] = 64'h0F0F_0F0F_0F0F_0F06; s_sec[5] = 0; s_ded[5] = 1;
    s_raw[6] = 64'hDEAD_BEEF_CAFE_F00D; s_syn[6] = 8'h00; s_exp[6] = 64'hDEAD_BEEF_CAFE_F00D; s_sec[6] = 0; s_ded[6] = 0;
    s_raw[7] = 64'h5555_5555_5555_5555; s_syn[7] = 8'h01; s_exp[7] = 64'h5555_5555_5555_5555; s_sec[7] = 1; s_ded[7] = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    #3;
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.sec_cnt", sec_cnt, 4'd0);
    check("rst.ded_cnt", ded_cnt, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst.in_ready", in_ready, 1'b1);

    send_single("clean", 64'h0123_4567_89AB_CDEF, 8'h00, 8'h00, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    check("clean.sec_cnt", sec_cnt, 4'd0);
    check("clean.ded_cnt", ded_cnt, 4'd0);

    send_single("sec_d0", 64'h0123_4567_89AB_CDEE, 8'h00, 8'h23, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    check("sec_d0.sec_cnt", sec_cnt, 4'd1);

    send_single("sec_c4", 64'h0123_4567_89AB_CDEF, 8'h10, 8'h10, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    check("sec_c4.sec_cnt", sec_cnt, 4'd2);

    send_single("ded_d03", 64'h0123_4567_89AB_CDE6, 8'h00, 8'h1E, 1'b1, 64'h0123_4567_89AB_CDE6, 1'b0, 1'b1);
    check("ded_d03.ded_cnt", ded_cnt, 4'd1);
    check("ded_d03.sec_cnt", sec_cnt, 4'd2);

    send_single("err_mismatch", 64'h0123_4567_89AB_CDEE, 8'h00, 8'h23, 1'b0, 64'h0123_4567_89AB_CDEE, 1'b0, 1'b1);
    send_single("odd_nocol", 64'hCAFE_0000_0000_BABE, 8'h00, 8'h7F, 1'b1, 64'hCAFE_0000_0000_BABE, 1'b0, 1'b1);
    send_single("sec_d63", 64'h8123_4567_89AB_CDEF, 8'h00, 8'h57, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    check("singles.sec_cnt", sec_cnt, 4'd3);
    check("singles.ded_cnt", ded_cnt, 4'd3);

    // Backpressure stream: producer and consumer/out_ready driver run side by side.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic acc;
          int   w;
          in_valid = 1'b1;
          in_code  = {8'h00, s_raw[i]};
          in_syn   = s_syn[i];
          in_err   = |s_syn[i];
          acc = 1'b0;
          w   = 0;
          while (!acc && w < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            w++;
          end
          if (!acc) check("stream.accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
        in_code  = '0;
        in_syn   = '0;
        in_err   = 1'b0;
      end
      begin
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 200) begin
          @(negedge clk);
          if (out_valid) begin
            check($sformatf("stream.data%0d", k), out_data, s_exp[k]);
            check($sformatf("stream.sec%0d", k), out_sec, s_sec[k]);
            check($sformatf("stream.ded%0d", k), out_ded, s_ded[k]);
            if (out_ready) k++;
          end
          @(posedge clk); #1;
          out_ready = pat[cyc % 4];
          cyc++;
        end
        check("stream.delivered", k, 8);
      end
    join
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stream.extra_word", out_valid, 1'b0);
    check("stream.sec_cnt", sec_cnt, 4'd6);
    check("stream.ded_cnt", ded_cnt, 4'd4);

    in_valid = 1'b1;
    in_code  = {8'h00, 64'h0123_4567_89AB_CDEE};
    in_syn   = 8'h23;
    in_err   = 1'b1;
    for (int i = 0; i < 20; i++) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sat.sec_cnt", sec_cnt, 4'd15);
    check("sat.ded_cnt", ded_cnt, 4'd4);

    // Clear lands on the same edge as a SEC word leaving the pipe.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("clr.out_sec", out_sec, 1'b1);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    check("clr.sec_cnt", sec_cnt, 4'd0);
    check("clr.ded_cnt", ded_cnt, 4'd0);
    check("clr.drained", out_valid, 1'b0);
    send_single("after_clr", 64'h0123_4567_89AB_CDEE, 8'h00, 8'h23, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    check("after_clr.sec_cnt", sec_cnt, 4'd1);

    // Fill both stages under stall, then reset mid-cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = {8'h00, 64'h1111_2222_3333_4444};
    in_syn    = 8'h00;
    in_err    = 1'b0;
    @(posedge clk); #1;
    in_code   = {8'h00, 64'h5555_6666_7777_8888};
    @(posedge clk); #1;
    in_valid  = 1'b0;
    check("full.out_valid", out_valid, 1'b1);
    check("full.in_ready", in_ready, 1'b0);
    check("full.out_data", out_data, 64'h1111_2222_3333_4444);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", out_valid, 1'b0);
    check("arst.in_ready", in_ready, 1'b1);
    check("arst.out_data", out_data, 64'h0);
    check("arst.sec_cnt", sec_cnt, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("flush.no_stale%0d", i), out_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
